// File: rtl/dsp_stream_packer.sv
// Packs serial operand words into the 116-bit DSP slice stream word using the field layout of the latched mode.
// Latency: 1 cycle from the last operand accept to stream_valid; double-buffered, so one word per N cycles is sustained.
// Backpressure: a finished word waits in HOLD (in_ready=0) while the output register is occupied and not draining.
// Optional: define DSP_PACK_RANGECHK_EN to flag operand bits above the target field width in err.
module dsp_stream_packer #(
    parameter int IN_W     = 32,
    parameter int STREAM_W = 116
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode_in,
    input  logic [3:0]          op_in,
    input  logic [IN_W-1:0]     in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [STREAM_W-1:0] stream,
    output logic [1:0]          stream_mode,
    output logic                stream_valid,
    input  logic                stream_ready,
    output logic                busy,
    output logic                err
);

    typedef enum logic {FILL, HOLD} state_t;

    state_t              state_q, state_d;
    logic [2:0]          slot_q, slot_d;
    logic [STREAM_W-1:0] asm_q, asm_d;
    logic [1:0]          mode_q, mode_d;

    logic                accept;
    logic [1:0]          cur_mode;
    logic [6:0]          fld_lo;
    logic [5:0]          fld_w;
    logic [2:0]          last_slot;
    logic [STREAM_W-1:0] data_ext;
    logic [STREAM_W-1:0] fld_mask;
    logic [STREAM_W-1:0] fld_val;
    logic [STREAM_W-1:0] op_field;
    logic [STREAM_W-1:0] packed_word;
    logic                word_done;
    logic                out_free;
    logic                load_out;
    logic [STREAM_W-1:0] out_word;
    logic [1:0]          out_mode;
    logic                err_set;

    assign in_ready = (state_q == FILL);
    assign busy     = (slot_q != 3'd0) || (state_q == HOLD);
    assign accept   = in_valid && in_ready;

    // Mode is only taken from the port on slot 0; later slots follow the latched copy.
    assign cur_mode = (slot_q == 3'd0) ? mode_in : mode_q;

    always_comb begin
        fld_lo    = 7'd0;
        fld_w     = 6'd0;
        last_slot = 3'd0;
        case (cur_mode)
            2'b00: begin
                last_slot = 3'd5;
                case (slot_q)
                    3'd0:    begin fld_lo = 7'd0;  fld_w = 6'd19; end
                    3'd1:    begin fld_lo = 7'd19; fld_w = 6'd18; end
                    3'd2:    begin fld_lo = 7'd37; fld_w = 6'd19; end
                    3'd3:    begin fld_lo = 7'd56; fld_w = 6'd18; end
                    3'd4:    begin fld_lo = 7'd74; fld_w = 6'd18; end
                    default: begin fld_lo = 7'd92; fld_w = 6'd18; end
                endcase
            end
            2'b01: begin
                last_slot = 3'd2;
                case (slot_q)
                    3'd0:    begin fld_lo = 7'd0;  fld_w = 6'd27; end
                    3'd1:    begin fld_lo = 7'd27; fld_w = 6'd26; end
                    default: begin fld_lo = 7'd53; fld_w = 6'd27; end
                endcase
            end
            2'b10: begin
                last_slot = 3'd2;
                fld_w     = 6'd32;
                case (slot_q)
                    3'd0:    fld_lo = 7'd0;
                    3'd1:    fld_lo = 7'd32;
                    default: fld_lo = 7'd64;
                endcase
            end
            default: begin
                last_slot = 3'd0;
                fld_w     = 6'd0;
            end
        endcase
    end

    assign data_ext = {{(STREAM_W-32){1'b0}}, in_data[31:0]};
    assign fld_mask = ~({STREAM_W{1'b1}} << fld_w);
    assign fld_val  = (data_ext & fld_mask) << fld_lo;
    assign op_field = {{(STREAM_W-100){1'b0}}, op_in, {96{1'b0}}};

    // Slot 0 starts from a clean word so stale fields of the previous word never leak through.
    always_comb begin
        packed_word = (slot_q == 3'd0) ? '0 : asm_q;
        packed_word = packed_word | fld_val;
        if (slot_q == 3'd0 && cur_mode == 2'b10)
            packed_word = packed_word | op_field;
    end

    assign word_done = accept && (cur_mode != 2'b11) && (slot_q == last_slot);
    assign out_free  = !stream_valid || stream_ready;
    assign load_out  = (word_done && out_free) || (state_q == HOLD && stream_ready);
    assign out_word  = (state_q == HOLD) ? asm_q  : packed_word;
    assign out_mode  = (state_q == HOLD) ? mode_q : cur_mode;

`ifdef DSP_PACK_RANGECHK_EN
    assign err_set = accept && ((cur_mode == 2'b11) || ((in_data >> fld_w) != '0));
`else
    assign err_set = accept && (cur_mode == 2'b11);
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        asm_d   = asm_q;
        mode_d  = mode_q;
        case (state_q)
            FILL: begin
                if (accept && cur_mode != 2'b11) begin
                    asm_d = packed_word;
                    if (slot_q == 3'd0)
                        mode_d = mode_in;
                    if (slot_q == last_slot) begin
                        slot_d = 3'd0;
                        if (!out_free)
                            state_d = HOLD;
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (stream_ready)
                    state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            slot_q       <= 3'd0;
            asm_q        <= '0;
            mode_q       <= 2'b00;
            stream       <= '0;
            stream_mode  <= 2'b00;
            stream_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            asm_q   <= asm_d;
            mode_q  <= mode_d;
            if (load_out) begin
                stream       <= out_word;
                stream_mode  <= out_mode;
                stream_valid <= 1'b1;
            end else if (stream_ready) begin
                stream_valid <= 1'b0;
            end
            if (err_set)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dsp_stream_packer.sv
// Directed and randomized bench for dsp_stream_packer; expected words come from a field-width model and a drain scoreboard.
module tb_dsp_stream_packer;

    logic         clk;
    logic         reset;
    logic [1:0]   mode_in;
    logic [3:0]   op_in;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_ready;
    logic [115:0] stream;
    logic [1:0]   stream_mode;
    logic         stream_valid;
    logic         stream_ready;
    logic         busy;
    logic         err;

    int           vecs = 0;
    int           miscompares = 0;
    int           stall_cycles = 0;
    int           drained = 0;
    int           bp_mode = 1;
    logic         exp_err = 1'b0;
    logic [115:0] last_exp;
    logic [115:0] exp_w_q[$];
    logic [1:0]   exp_m_q[$];

    dsp_stream_packer #(.IN_W(32), .STREAM_W(116)) dut (
        .clk          (clk),
        .reset        (reset),
        .mode_in      (mode_in),
        .op_in        (op_in),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stream       (stream),
        .stream_mode  (stream_mode),
        .stream_valid (stream_valid),
        .stream_ready (stream_ready),
        .busy         (busy),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
        $fatal(1, "watchdog expired");
    end

    // Sink: 0 = stalled, 1 = always ready, 2 = random
    initial begin
        stream_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       stream_ready = 1'b0;
                1:       stream_ready = 1'b1;
                default: stream_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int field_w(input logic [1:0] m, input int i);
        int w6[6];
        case (m)
            2'd0:    w6 = '{19, 18, 19, 18, 18, 18};
            2'd1:    w6 = '{27, 26, 27, 0, 0, 0};
            default: w6 = '{32, 32, 32, 0, 0, 0};
        endcase
        return w6[i];
    endfunction

    function automatic int n_of(input logic [1:0] m);
        return (m == 2'd0) ? 6 : 3;
    endfunction

    // Fields laid end to end from bit 0; each operand reduced modulo 2**width, op code follows the last field.
    function automatic logic [115:0] model_word(input logic [1:0] m, input logic [3:0] o, input logic [5:0][31:0] ops);
        logic [115:0] acc;
        int pos;
        acc = '0;
        pos = 0;
        for (int i = 0; i < n_of(m); i++) begin
            acc = acc | ((116'(ops[i]) % (116'(1) << field_w(m, i))) << pos);
            pos += field_w(m, i);
        end
        if (m == 2'd2)
            acc = acc | (116'(o) << pos);
        return acc;
    endfunction

    function automatic logic model_viol(input logic [1:0] m, input logic [5:0][31:0] ops);
        logic v;
        v = 1'b0;
        for (int i = 0; i < n_of(m); i++)
            if (field_w(m, i) < 32 && 64'(ops[i]) >= (64'd1 << field_w(m, i)))
                v = 1'b1;
        return v;
    endfunction

    function automatic logic [5:0][31:0] mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                                            input logic [31:0] d, input logic [31:0] e, input logic [31:0] f);
        logic [5:0][31:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
        return r;
    endfunction

    // Called between a rising edge and the next falling edge; returns 1 time unit after the accepting edge.
    task automatic put_op(input logic [1:0] m, input logic [3:0] o, input logic [31:0] d);
        int waits;
        waits    = 0;
        mode_in  = m;
        op_in    = o;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        stall_cycles += waits;
        if (!in_ready)
            chk("in_ready_wait", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [1:0] m, input logic [3:0] o, input logic [5:0][31:0] ops);
        last_exp = model_word(m, o, ops);
        exp_w_q.push_back(last_exp);
        exp_m_q.push_back(m);
`ifdef DSP_PACK_RANGECHK_EN
        if (model_viol(m, ops))
            exp_err = 1'b1;
`endif
        for (int i = 0; i < n_of(m); i++)
            put_op(m, o, ops[i]);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && stream_valid && stream_ready) begin
            if (exp_w_q.size() == 0) begin
                chk("spurious_word", 128'(stream_valid), 128'(0));
            end else begin
                logic [115:0] w;
                logic [1:0]   m;
                w = exp_w_q.pop_front();
                m = exp_m_q.pop_front();
                chk("drain_word", 128'(stream), 128'(w));
                chk("drain_mode", 128'(stream_mode), 128'(m));
                drained++;
            end
        end
    end

    initial begin
        logic [115:0] lit;
        logic [115:0] wa;
        logic [115:0] wb;
        logic [5:0][31:0] ops;
        logic [1:0] rm;
        int d0;
        int waitc;

        reset    = 1'b1;
        in_valid = 1'b0;
        mode_in  = 2'b00;
        op_in    = 4'd0;
        in_data  = 32'd0;
        bp_mode  = 1;
        step(3);
        chk("rst_stream_valid", 128'(stream_valid), 128'(0));
        chk("rst_stream", 128'(stream), 128'(0));
        chk("rst_stream_mode", 128'(stream_mode), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        reset = 1'b0;
        step(1);

        // Mode 00, sink always ready
        send_word(2'b00, 4'd0, mk(2, 3, 5, 6, 1, 4));
        lit = {6'd0, 18'd4, 18'd1, 18'd6, 19'd5, 18'd3, 19'd2};
        chk("m00_valid", 128'(stream_valid), 128'(1));
        chk("m00_stream", 128'(stream), 128'(lit));
        chk("m00_mode", 128'(stream_mode), 128'(0));
        step(1);
        chk("m00_valid_one_cycle", 128'(stream_valid), 128'(0));

        // Mode 01 with mode_in changing after slot 0
        exp_w_q.push_back(model_word(2'b01, 4'd0, mk(2, 3, 1, 0, 0, 0)));
        exp_m_q.push_back(2'b01);
        put_op(2'b01, 4'd0, 32'd2);
        put_op(2'b10, 4'd0, 32'd3);
        put_op(2'b10, 4'd0, 32'd1);
        lit = {36'd0, 27'd1, 26'd3, 27'd2};
        chk("m01_stream", 128'(stream), 128'(lit));
        chk("m01_mode", 128'(stream_mode), 128'(1));
        chk("m01_valid", 128'(stream_valid), 128'(1));
        step(1);

        // Mode 10 with FP opcode
        send_word(2'b10, 4'b0011, mk(32'hC0D1C2F2, 32'h3E1FF44D, 32'h3F5A572F, 0, 0, 0));
        lit = {16'd0, 4'b0011, 32'h3F5A572F, 32'h3E1FF44D, 32'hC0D1C2F2};
        chk("m10_stream", 128'(stream), 128'(lit));
        chk("m10_mode", 128'(stream_mode), 128'(2));
        step(1);

        // Backpressure: two words against a stalled sink
        bp_mode = 0;
        step(1);
        send_word(2'b01, 4'd0, mk($urandom, $urandom, $urandom, 0, 0, 0));
        wa = last_exp;
        chk("bp_first_valid", 128'(stream_valid), 128'(1));
        send_word(2'b01, 4'd0, mk($urandom, $urandom, $urandom, 0, 0, 0));
        wb = last_exp;
        chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
        chk("bp_hold_busy", 128'(busy), 128'(1));
        chk("bp_hold_stream", 128'(stream), 128'(wa));
        step(2);
        chk("bp_hold_in_ready_later", 128'(in_ready), 128'(0));
        chk("bp_hold_valid_later", 128'(stream_valid), 128'(1));
        bp_mode = 1;
        step(1);
        bp_mode = 0;
        chk("bp_second_stream", 128'(stream), 128'(wb));
        chk("bp_second_valid", 128'(stream_valid), 128'(1));
        chk("bp_in_ready_back", 128'(in_ready), 128'(1));
        chk("bp_busy_clear", 128'(busy), 128'(0));
        step(1);
        chk("bp_second_still_held", 128'(stream), 128'(wb));
        bp_mode = 1;
        step(1);
        chk("bp_drained", 128'(stream_valid), 128'(0));

        // Mode 11 operand: discarded, sticky error
        put_op(2'b11, 4'd0, $urandom);
        exp_err = 1'b1;
        chk("m11_err", 128'(err), 128'(1));
        chk("m11_busy", 128'(busy), 128'(0));
        step(3);
        chk("m11_no_word", 128'(stream_valid), 128'(0));
        chk("m11_err_sticky", 128'(err), 128'(1));
        send_word(2'b01, 4'd0, mk(7, 8, 9, 0, 0, 0));
        chk("m11_then_word", 128'(stream), 128'(last_exp));
        chk("m11_err_kept", 128'(err), 128'(1));
        step(1);

        // Reset with an output word held and a partial word in assembly
        bp_mode = 0;
        step(1);
        send_word(2'b00, 4'd0, mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        put_op(2'b00, 4'd0, 32'h1234);
        put_op(2'b00, 4'd0, 32'h5678);
        put_op(2'b00, 4'd0, 32'h9ABC);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_w_q.delete();
        exp_m_q.delete();
        exp_err = 1'b0;
        chk("rst2_err", 128'(err), 128'(0));
        chk("rst2_valid", 128'(stream_valid), 128'(0));
        chk("rst2_busy", 128'(busy), 128'(0));
        chk("rst2_in_ready", 128'(in_ready), 128'(1));
        bp_mode = 1;
        send_word(2'b00, 4'd0, mk(11, 22, 33, 44, 55, 66));
        chk("rst2_fresh_word", 128'(stream), 128'(last_exp));
        step(1);

        // Sustained throughput with the sink always ready
        stall_cycles = 0;
        d0 = drained;
        for (int k = 0; k < 4; k++)
            send_word(2'b01, 4'd0, mk($urandom, $urandom, $urandom, 0, 0, 0));
        for (int k = 0; k < 2; k++)
            send_word(2'b00, 4'd0, mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        step(1);
        chk("tput_no_stall", 128'(stall_cycles), 128'(0));
        chk("tput_drained", 128'(drained - d0), 128'(6));

        // Randomized modes, operands and sink backpressure
        bp_mode = 2;
        for (int k = 0; k < 30; k++) begin
            rm = 2'($urandom_range(0, 2));
            send_word(rm, 4'($urandom), mk($urandom, $urandom, $urandom, $urandom, $urandom, $urandom));
        end
        bp_mode = 1;
        waitc = 0;
        while ((exp_w_q.size() != 0 || stream_valid) && waitc < 200) begin
            step(1);
            waitc++;
        end
        chk("rand_all_drained", 128'(exp_w_q.size()), 128'(0));
        chk("rand_err", 128'(err), 128'(exp_err));

`ifdef DSP_PACK_RANGECHK_EN
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        exp_err = 1'b0;
        send_word(2'b00, 4'd0, mk(1, 32'h00040000, 2, 3, 4, 5));
        chk("rc_err", 128'(err), 128'(1));
        chk("rc_field_zero", 128'(stream[36:19]), 128'(0));
        chk("rc_stream", 128'(stream), 128'(last_exp));
        step(2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/dsp_stream_packer.md
Name: dsp_stream_packer

Overview:
- Upstream operand-assembly stage for the combined Stratix10 DSP slice.
- Accepts a serial stream of operand words over a valid/ready handshake and packs them into the 116-bit `stream` word, using the field layout of the latched mode.
- Presents each packed word, with its mode, to the slice through a one-entry output register; `stream_valid & stream_ready` drives the slice `enable`.
- Double-buffered: assembly of the next word proceeds while the current word waits at the output.

Parameters:
- IN_W, 32, operand input width; must be >= 32. Bits above a field's width are dropped (see Optional Feature).
- STREAM_W, 116, packed stream width; fixed at 116, not to be overridden.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- mode_in  in  2  mode for the word being assembled; sampled only with slot-0 operand
- op_in  in  4  FP opcode, mode 10 only; sampled with slot-0 operand
- in_data  in  IN_W  operand word
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid & in_ready
- stream  out  116  packed operand word to slice
- stream_mode  out  2  mode of the word on stream
- stream_valid  out  1  output register holds a word
- stream_ready  in  1  slice consumes the word this cycle
- busy  out  1  assembly in progress (slot counter != 0 or HOLD)
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (synchronous, active-high): state=FILL, slot=0, assembly register=0, stream=0, stream_mode=0, stream_valid=0, err=0, in_ready=1 from the first cycle after reset.
- Operands per word (N): mode 00 -> 6, mode 01 -> 3, mode 10 -> 3, mode 11 -> 1.
  - A mode-11 operand is consumed and discarded; err is set and no word is produced.
- Slot-to-field mapping. Slot 0 fills the LSB field. All unlisted bits are 0.
  - Mode 00: s0 [18:0] 19b, s1 [36:19] 18b, s2 [55:37] 19b, s3 [73:56] 18b, s4 [91:74] 18b, s5 [109:92] 18b. Bits [115:110]=0.
  - Mode 01: s0 [26:0] 27b, s1 [52:27] 26b, s2 [79:53] 27b. Bits [115:80]=0.
  - Mode 10: s0 [31:0] 32b, s1 [63:32] 32b, s2 [95:64] 32b, op_in at [99:96]. Bits [115:100]=0.
- Mode and op are latched on slot-0 acceptance. Changes to mode_in/op_in in later slots are ignored.
- States:
  - FILL: accept operands, slot increments on each accept.
  - HOLD: word complete, output register occupied.
- Transfer on acceptance of slot N-1:
  - If stream_valid=0, or stream_ready=1 in the same cycle, the packed word moves to the output register at that edge. stream_valid=1 the next cycle. Latency is 1 cycle from the last operand to stream_valid. slot returns to 0 and the state stays FILL.
  - Otherwise go to HOLD with in_ready=0. Transfer occurs in the first cycle with stream_ready=1; that cycle returns to FILL with in_ready=1 the following cycle.
- in_ready = (state==FILL). Combinational only from registered state; no dependence on in_valid.
- Output register: stream_valid clears on stream_ready when no transfer occurs that same cycle. A simultaneous drain and transfer keeps stream_valid=1 with the new word (back-to-back, no bubble).
- stream_ready while stream_valid=0 is ignored.
- Reset mid-word discards the partial word and any held or output word.
- Throughput: one word per N cycles sustained, with no idle cycles when stream_ready is held at 1.

Optional Feature:
- Macro: DSP_PACK_RANGECHK_EN.
- Defined: on each accept, if any in_data bit above the target field width is nonzero, set err (sticky). The operand is still truncated and packed.
  - Mode 10 fields are 32b, so only bits above 32 are checked when IN_W > 32.
- Undefined: no range checking. err is set only by mode-11 operands.

Test Plan:
- Mode 00, stream_ready=1, operands 2,3,5,6,1,4 -> one cycle after the 6th accept: stream={6'd0,18'd4,18'd1,18'd6,19'd5,18'd3,19'd2}, stream_mode=00, stream_valid=1 for exactly one cycle.
- Mode 01, operands 2,3,1 -> stream={36'd0,27'd1,26'd3,27'd2}. Change mode_in to 10 at slot 1; the result is unchanged and stream_mode=01.
- Mode 10, op_in=4'b0011, operands 32'hC0D1C2F2, 32'h3E1FF44D, 32'h3F5A572F -> stream={16'd0,4'b0011,32'h3F5A572F,32'h3E1FF44D,32'hC0D1C2F2}.
- Backpressure: stream_ready=0, two complete mode-01 words -> first on stream; after the 2nd word completes, in_ready=0 (HOLD). Assert stream_ready for 1 cycle -> 2nd word appears the next cycle, and in_ready returns to 1 one cycle after the transfer. No words lost or duplicated.
- Reset after 3 mode-00 operands, then 6 fresh operands -> first output word contains only the fresh operands. err=0 and stream_valid=0 in the cycle after reset.
- Mode 11 operand -> no stream_valid, err=1 and stays set. With DSP_PACK_RANGECHK_EN: mode 00, slot 1 = 32'h00040000 -> err=1, field [36:19]=0.
